mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single byte-wide program/data memory between the CPU bus and a host (program-loader/debug) port. It grants at most one access per cycle: round-robin on contention, with a bounded lock so the CPU's two-byte instruction fetch stays atomic. Read data returns registered one cycle after grant. The block sits between `cpu`/host logic and the memory array, replacing the static `startProgram` mux.

## Interface
- `ADDR_W`, 10, memory address width (1024 bytes)
- `DATA_W`, 8, memory data width
- `MAX_LOCK`, 4, maximum consecutive locked grants while the other port is waiting
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `c_req`, `h_req`  in  1  access request (CPU, host)
- `c_we`, `h_we`  in  1  1 = write, 0 = read
- `c_lock`, `h_lock`  in  1  keep ownership for the next request
- `c_addr`, `h_addr`  in  ADDR_W  byte address
- `c_wdata`, `h_wdata`  in  DATA_W  write byte
- `c_gnt`, `h_gnt`  out  1  access accepted this cycle (combinational)
- `c_rvalid`, `h_rvalid`  out  1  read data valid (cycle after read grant)
- `rdata`  out  DATA_W  registered read byte, shared by both ports
- `mem_addr`  out  ADDR_W  to memory
- `mem_we`  out  1  memory write strobe
- `mem_wdata`  out  DATA_W  memory write byte
- `mem_rdata`  in  DATA_W  asynchronous memory read data

## Operation
- Registered state: `last` (last winner: 0 = CPU, 1 = host), `lock_own` (valid + id), `lock_cnt` (`$clog2(MAX_LOCK+1)` bits), `rv_c`, `rv_h`, `rdata`.
- Winner selection, in priority order:
  - Lock valid, owner requesting, and (`lock_cnt < MAX_LOCK` or other port idle): owner wins.
  - Otherwise, both requesting: the port ≠ `last` wins.
  - Otherwise, the single requester wins; none if neither requests.
- Granted port: `gnt` = 1. Memory outputs are driven from the winner; `mem_we` = winner `we`. With no winner, memory outputs are 0.
- Read grant: at the next edge, `rdata` ← `mem_rdata` and the winner's `rv` ← 1. Otherwise `rv` ← 0 and `rdata` holds its value.
- Write grant: memory is written at the edge. No rvalid is produced.
- `last` ← winner on every grant.
- Lock update on a grant:
  - Winner `lock` = 1: `lock_own` ← winner. `lock_cnt` ← `lock_cnt` + 1 if the same owner continues, else 1.
  - Winner `lock` = 0: lock cleared, `lock_cnt` ← 0.
- Lock update on a cycle where the owner's `req` = 0: lock cleared.
- Forced release:
  - When `lock_cnt == MAX_LOCK` and the other port requests, the other port wins by round-robin.
  - The lock is cleared and `lock_cnt` ← 0.
  - `lock_cnt` saturates at `MAX_LOCK`.
- Simultaneous `c_req` and `h_req` on the same address: only the winner accesses; the loser retries. No merging.

## Timing
- Reset values: `last` = 1 (CPU wins the first tie), lock invalid, `lock_cnt` = 0, `rv_c` = `rv_h` = 0, `rdata` = 0.
- While `reset` is high: both grants = 0 and `mem_we` = 0.
- Reset asserted mid-operation: a pending `rvalid` is dropped next cycle, and no write occurs in that cycle.
- Grant latency: 0 cycles (same-cycle combinational). Read latency: 1 cycle (`rvalid` at t+1).
- Handshake: the requester holds `req`/`addr`/`we`/`wdata` stable until it sees `gnt`. The transfer completes in the `gnt` cycle. `gnt` never asserts without `req`.
- Back-to-back grants to one port: one per cycle, and `rvalid` follows each read one cycle later.
- Maximum wait for a requesting port: `MAX_LOCK` + 1 cycles.

## Structure
- Shared package `mem_arb_pkg` holds:
  - `REQ_CPU` = 0, `REQ_HOST` = 1
  - default `ADDR_W` / `DATA_W`
  - winner-id type (1 bit)
- Sub-module `rr_pick2`: combinational 2-way round-robin picker (inputs: two `req`s, `last`; output: winner valid + id). Lock override lives in `mem_arbiter` itself.

## Test plan
- Single read: `h_req`=1, `h_we`=0, `h_addr`=0x010, memory[0x010]=0xA5 -> `h_gnt`=1 in cycle t; `h_rvalid`=1, `rdata`=0xA5 in t+1; `c_rvalid`=0.
- Contention: both ports request reads continuously after reset -> grants alternate CPU, host, CPU, host. Each `rvalid` appears one cycle after its grant.
- Atomic fetch: CPU reads 0x000 with `c_lock`=1, then 0x001 with `c_lock`=0, while host requests throughout -> CPU granted two consecutive cycles; host granted in the third.
- Lock bound: CPU holds `c_lock`=1 and `req` indefinitely, host requesting, `MAX_LOCK`=4 -> CPU wins 4 cycles, host wins cycle 5, lock cleared.
- Write/readback: host writes 0x3C to 0x200, then CPU reads 0x200 -> `mem_we`=1 only in the host grant cycle; CPU `rdata`=0x3C.
- Reset mid-read: `reset` asserted in the cycle after a read grant -> `rvalid`=0 and `rdata`=0 next cycle. The first post-reset tie goes to CPU.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the CPU/host memory arbiter.
// Port ids double as the round-robin "last winner" encoding.
package mem_arb_pkg;

   typedef logic [0:0] win_id_t;

   localparam win_id_t REQ_CPU  = 1'b0;
   localparam win_id_t REQ_HOST = 1'b1;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      LK_NONE = 2'd0,
      LK_CPU  = 2'd1,
      LK_HOST = 2'd2
   } lock_st_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes for the CPU and host ports plus the memory-array side.
// The arbiter uses the slave modport; the requesters and memory model use master.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              c_req, h_req;
   logic              c_we, h_we;
   logic              c_lock, h_lock;
   logic [ADDR_W-1:0] c_addr, h_addr;
   logic [DATA_W-1:0] c_wdata, h_wdata;
   logic              c_gnt, h_gnt;
   logic              c_rvalid, h_rvalid;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  c_req, h_req, c_we, h_we, c_lock, h_lock,
      input  c_addr, h_addr, c_wdata, h_wdata, mem_rdata,
      output c_gnt, h_gnt, c_rvalid, h_rvalid, rdata,
      output mem_addr, mem_we, mem_wdata
   );

   modport master (
      output c_req, h_req, c_we, h_we, c_lock, h_lock,
      output c_addr, h_addr, c_wdata, h_wdata, mem_rdata,
      input  c_gnt, h_gnt, c_rvalid, h_rvalid, rdata,
      input  mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the port that did not win last time goes.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic    req_c,
   input  logic    req_h,
   input  win_id_t last,
   output logic    win_vld,
   output win_id_t win_id
);

   always_comb begin
      win_vld = req_c | req_h;
      win_id  = REQ_CPU;
      if (req_c && req_h) begin
         win_id = ~last;
      end else if (req_h) begin
         win_id = REQ_HOST;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide memory between the CPU bus and the host loader port.
// One grant per cycle, round-robin on contention, bounded lock for atomic fetches.
//
// lock state | meaning
// LK_NONE    | no port holds ownership; plain round-robin
// LK_CPU     | CPU keeps ownership while requesting, up to MAX_LOCK grants
// LK_HOST    | host keeps ownership while requesting, up to MAX_LOCK grants
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_LOCK = 4
)(
   input  logic           clk,
   input  logic           reset,
   mem_arbiter_if.slave   bus
);

   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   win_id_t           last_q, last_d;
   lock_st_t          lock_st_q, lock_st_d;
   logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic              rv_c_q, rv_c_d;
   logic              rv_h_q, rv_h_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              rr_vld;
   win_id_t           rr_id;
   logic              lock_vld, req_own, req_oth, at_max, hold, forced;
   win_id_t           lock_own;
   logic              win_vld, win_we, win_lock;
   win_id_t           win_id;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   rr_pick2 u_pick (
      .req_c   (bus.c_req),
      .req_h   (bus.h_req),
      .last    (last_q),
      .win_vld (rr_vld),
      .win_id  (rr_id)
   );

   always_comb begin
      lock_vld = (lock_st_q != LK_NONE);
      lock_own = (lock_st_q == LK_HOST) ? REQ_HOST : REQ_CPU;
      req_own  = (lock_own == REQ_HOST) ? bus.h_req : bus.c_req;
      req_oth  = (lock_own == REQ_HOST) ? bus.c_req : bus.h_req;
      at_max   = (lock_cnt_q == CNT_MAX);
      hold     = lock_vld && req_own && (!at_max || !req_oth);
      // Owner has used its whole budget and the other side is waiting.
      forced   = lock_vld && req_own && at_max && req_oth;

      win_vld  = !reset && (hold || rr_vld);
      win_id   = hold ? lock_own : rr_id;

      win_we    = (win_id == REQ_HOST) ? bus.h_we    : bus.c_we;
      win_lock  = (win_id == REQ_HOST) ? bus.h_lock  : bus.c_lock;
      win_addr  = (win_id == REQ_HOST) ? bus.h_addr  : bus.c_addr;
      win_wdata = (win_id == REQ_HOST) ? bus.h_wdata : bus.c_wdata;

      bus.c_gnt     = win_vld && (win_id == REQ_CPU);
      bus.h_gnt     = win_vld && (win_id == REQ_HOST);
      bus.mem_addr  = win_vld ? win_addr  : '0;
      bus.mem_we    = win_vld && win_we;
      bus.mem_wdata = win_vld ? win_wdata : '0;
      bus.c_rvalid  = rv_c_q;
      bus.h_rvalid  = rv_h_q;
      bus.rdata     = rdata_q;

      last_d     = last_q;
      lock_st_d  = lock_st_q;
      lock_cnt_d = lock_cnt_q;
      rv_c_d     = bus.c_gnt && !win_we;
      rv_h_d     = bus.h_gnt && !win_we;
      rdata_d    = (win_vld && !win_we) ? bus.mem_rdata : rdata_q;

      if (win_vld) begin
         last_d = win_id;
         if (forced || !win_lock) begin
            lock_st_d  = LK_NONE;
            lock_cnt_d = '0;
         end else begin
            lock_st_d = (win_id == REQ_HOST) ? LK_HOST : LK_CPU;
            if (lock_vld && (lock_own == win_id)) begin
               lock_cnt_d = at_max ? CNT_MAX : lock_cnt_q + CNT_ONE;
            end else begin
               lock_cnt_d = CNT_ONE;
            end
         end
      end else if (lock_vld && !req_own) begin
         lock_st_d  = LK_NONE;
         lock_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q     <= REQ_HOST;
         lock_st_q  <= LK_NONE;
         lock_cnt_q <= '0;
         rv_c_q     <= 1'b0;
         rv_h_q     <= 1'b0;
         rdata_q    <= '0;
      end else begin
         last_q     <= last_d;
         lock_st_q  <= lock_st_d;
         lock_cnt_q <= lock_cnt_d;
         rv_c_q     <= rv_c_d;
         rv_h_q     <= rv_h_d;
         rdata_q    <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset sequences, and a
// randomized run checked against a port-indexed reference model.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 10;
   localparam int DW = 8;
   localparam int ML = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [7:0] pat(int i);
      if (i == 16) return 8'hA5;
      return 8'((i * 7 + 3) & 255);
   endfunction

   logic [7:0] mem [0:1023];
   bit mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
         mem_ready <= 1'b1;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
   end
   assign bus.mem_rdata = mem[bus.mem_addr];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      bit cr, cw, cl; logic [9:0] ca; logic [7:0] cd;
      bit hr, hw, hl; logic [9:0] ha; logic [7:0] hd;
      bit ecg, ehg, ewe, ecrv, ehrv; logic [7:0] erd;
   } vec_t;

   function automatic vec_t mk(int cr, int cw, int cl, int ca, int cd,
                               int hr, int hw, int hl, int ha, int hd,
                               int ecg, int ehg, int ewe, int ecrv, int ehrv, int erd);
      vec_t v;
      v.cr = (cr != 0); v.cw = (cw != 0); v.cl = (cl != 0); v.ca = 10'(ca); v.cd = 8'(cd);
      v.hr = (hr != 0); v.hw = (hw != 0); v.hl = (hl != 0); v.ha = 10'(ha); v.hd = 8'(hd);
      v.ecg = (ecg != 0); v.ehg = (ehg != 0); v.ewe = (ewe != 0);
      v.ecrv = (ecrv != 0); v.ehrv = (ehrv != 0); v.erd = 8'(erd);
      return v;
   endfunction

   task automatic drive(input bit cr, input bit cw, input bit cl, input int ca, input int cd,
                        input bit hr, input bit hw, input bit hl, input int ha, input int hd);
      bus.c_req = cr; bus.c_we = cw; bus.c_lock = cl; bus.c_addr = 10'(ca); bus.c_wdata = 8'(cd);
      bus.h_req = hr; bus.h_we = hw; bus.h_lock = hl; bus.h_addr = 10'(ha); bus.h_wdata = 8'(hd);
   endtask

   // Reference model state, indexed by port id (0 = CPU, 1 = host).
   int         m_last, m_lkv, m_lko, m_lkn, m_rdata;
   int         m_rv [2];
   logic [7:0] shadow [0:1023];
   bit         pend [2];
   bit         rwe [2];
   bit         rlk [2];
   int         raddr [2];
   int         rwd [2];
   int         waitc [2];

   vec_t tbl [$];

   initial begin
      for (int i = 0; i < 1024; i++) shadow[i] = pat(i);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);

      // Requests while in reset must not be granted nor write memory.
      #1 drive(1, 0, 0, 'h005, 0, 1, 1, 0, 'h006, 'h77);
      @(negedge clk);
      chk("rst_c_gnt", int'(bus.c_gnt), 0);
      chk("rst_h_gnt", int'(bus.h_gnt), 0);
      chk("rst_mem_we", int'(bus.mem_we), 0);
      chk("rst_rdata", int'(bus.rdata), 0);

      //        cr cw cl ca     cd  hr hw hl ha     hd     cg hg we crv hrv rdata
      tbl.push_back(mk(0,0,0,0,     0,  1,0,0,'h010,0,     0,1,0,0,0,'h00));
      tbl.push_back(mk(0,0,0,0,     0,  0,0,0,0,    0,     0,0,0,0,1,'hA5));
      tbl.push_back(mk(1,0,0,'h020, 0,  1,0,0,'h021,0,     1,0,0,0,0,'hA5));
      tbl.push_back(mk(1,0,0,'h022, 0,  1,0,0,'h021,0,     0,1,0,1,0,'hE3));
      tbl.push_back(mk(1,0,0,'h022, 0,  1,0,0,'h023,0,     1,0,0,0,1,'hEA));
      tbl.push_back(mk(0,0,0,0,     0,  1,0,0,'h023,0,     0,1,0,1,0,'hF1));
      tbl.push_back(mk(0,0,0,0,     0,  0,0,0,0,    0,     0,0,0,0,1,'hF8));
      tbl.push_back(mk(1,0,1,'h000, 0,  1,0,0,'h030,0,     1,0,0,0,0,'hF8));
      tbl.push_back(mk(1,0,0,'h001, 0,  1,0,0,'h030,0,     1,0,0,1,0,'h03));
      tbl.push_back(mk(1,0,0,'h002, 0,  1,0,0,'h030,0,     0,1,0,1,0,'h0A));
      tbl.push_back(mk(1,0,0,'h002, 0,  0,0,0,0,    0,     1,0,0,0,1,'h53));
      tbl.push_back(mk(0,0,0,0,     0,  0,0,0,0,    0,     0,0,0,1,0,'h11));
      tbl.push_back(mk(1,0,1,'h040, 0,  0,0,0,0,    0,     1,0,0,0,0,'h11));
      tbl.push_back(mk(1,0,1,'h041, 0,  1,0,0,'h050,0,     1,0,0,1,0,'hC3));
      tbl.push_back(mk(1,0,1,'h042, 0,  1,0,0,'h050,0,     1,0,0,1,0,'hCA));
      tbl.push_back(mk(1,0,1,'h043, 0,  1,0,0,'h050,0,     1,0,0,1,0,'hD1));
      tbl.push_back(mk(1,0,1,'h044, 0,  1,0,0,'h050,0,     0,1,0,1,0,'hD8));
      tbl.push_back(mk(1,0,1,'h044, 0,  0,0,0,0,    0,     1,0,0,0,1,'h33));
      tbl.push_back(mk(0,0,0,0,     0,  0,0,0,0,    0,     0,0,0,1,0,'hDF));
      tbl.push_back(mk(0,0,0,0,     0,  1,1,0,'h200,'h3C,  0,1,1,0,0,'hDF));
      tbl.push_back(mk(1,0,0,'h200, 0,  0,0,0,0,    0,     1,0,0,0,0,'hDF));
      tbl.push_back(mk(0,0,0,0,     0,  0,0,0,0,    0,     0,0,0,1,0,'h3C));

      @(posedge clk);
      #1 reset = 1'b0;
      foreach (tbl[k]) begin
         if (k != 0) begin
            @(posedge clk);
            #1;
         end
         drive(tbl[k].cr, tbl[k].cw, tbl[k].cl, int'(tbl[k].ca), int'(tbl[k].cd),
               tbl[k].hr, tbl[k].hw, tbl[k].hl, int'(tbl[k].ha), int'(tbl[k].hd));
         @(negedge clk);
         chk($sformatf("vec%0d_c_gnt", k), int'(bus.c_gnt), int'(tbl[k].ecg));
         chk($sformatf("vec%0d_h_gnt", k), int'(bus.h_gnt), int'(tbl[k].ehg));
         chk($sformatf("vec%0d_mem_we", k), int'(bus.mem_we), int'(tbl[k].ewe));
         chk($sformatf("vec%0d_c_rvalid", k), int'(bus.c_rvalid), int'(tbl[k].ecrv));
         chk($sformatf("vec%0d_h_rvalid", k), int'(bus.h_rvalid), int'(tbl[k].ehrv));
         chk($sformatf("vec%0d_rdata", k), int'(bus.rdata), int'(tbl[k].erd));
      end
      shadow['h200] = 8'h3C;

      // Reset lands the cycle after a read grant.
      @(posedge clk); #1 drive(0, 0, 0, 0, 0, 1, 0, 0, 'h010, 0);
      @(negedge clk);
      chk("mid_h_gnt", int'(bus.h_gnt), 1);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("mid_h_rvalid", int'(bus.h_rvalid), 1);
      chk("mid_rdata", int'(bus.rdata), 'hA5);
      chk("mid_rst_h_gnt", int'(bus.h_gnt), 0);
      @(posedge clk); #1 reset = 1'b0;
      drive(1, 0, 0, 'h001, 0, 1, 0, 0, 'h002, 0);
      @(negedge clk);
      chk("post_h_rvalid", int'(bus.h_rvalid), 0);
      chk("post_rdata", int'(bus.rdata), 0);
      chk("post_tie_c_gnt", int'(bus.c_gnt), 1);
      chk("post_tie_h_gnt", int'(bus.h_gnt), 0);
      @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("post_c_rvalid", int'(bus.c_rvalid), 1);
      chk("post_c_rdata", int'(bus.rdata), 'h0A);

      // Randomized traffic against the reference model, starting from reset.
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      m_last = 1; m_lkv = 0; m_lko = 0; m_lkn = 0; m_rdata = 0;
      for (int p = 0; p < 2; p++) begin
         m_rv[p] = 0; pend[p] = 1'b0; waitc[p] = 0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int w;
         bit forced;
         if (cyc != 0) begin
            @(posedge clk);
            #1;
         end
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(99) < 75) begin
               pend[p]  = 1'b1;
               rwe[p]   = ($urandom_range(3) == 0);
               rlk[p]   = ($urandom_range(1) == 1);
               raddr[p] = $urandom_range(31);
               rwd[p]   = $urandom_range(255);
               waitc[p] = 0;
            end
         end
         drive(pend[0], rwe[0], rlk[0], raddr[0], rwd[0],
               pend[1], rwe[1], rlk[1], raddr[1], rwd[1]);
         @(negedge clk);

         chk("rnd_c_rvalid", int'(bus.c_rvalid), m_rv[0]);
         chk("rnd_h_rvalid", int'(bus.h_rvalid), m_rv[1]);
         chk("rnd_rdata", int'(bus.rdata), m_rdata);

         w = -1;
         if (m_lkv != 0 && pend[m_lko] && (m_lkn < ML || !pend[1 - m_lko])) w = m_lko;
         else if (pend[0] && pend[1]) w = 1 - m_last;
         else if (pend[0]) w = 0;
         else if (pend[1]) w = 1;
         forced = (m_lkv != 0) && pend[m_lko] && (m_lkn == ML) && pend[1 - m_lko];

         chk("rnd_c_gnt", int'(bus.c_gnt), int'(w == 0));
         chk("rnd_h_gnt", int'(bus.h_gnt), int'(w == 1));
         chk("rnd_mem_we", int'(bus.mem_we), (w >= 0) ? int'(rwe[w]) : 0);
         if (w >= 0) begin
            chk("rnd_mem_addr", int'(bus.mem_addr), raddr[w]);
            if (rwe[w]) chk("rnd_mem_wdata", int'(bus.mem_wdata), rwd[w]);
         end

         for (int p = 0; p < 2; p++) begin
            m_rv[p] = 0;
            if (pend[p]) waitc[p]++;
         end
         if (w >= 0) begin
            chk("rnd_wait_bound", int'(waitc[w] <= ML + 1), 1);
            m_last = w;
            if (rwe[w]) begin
               shadow[raddr[w]] = 8'(rwd[w]);
            end else begin
               m_rv[w] = 1;
               m_rdata = int'(shadow[raddr[w]]);
            end
            if (forced || !rlk[w]) begin
               m_lkv = 0; m_lkn = 0;
            end else begin
               m_lkn = (m_lkv != 0 && m_lko == w) ? ((m_lkn + 1 > ML) ? ML : m_lkn + 1) : 1;
               m_lkv = 1; m_lko = w;
            end
            pend[w] = 1'b0;
         end else if (m_lkv != 0 && !pend[m_lko]) begin
            m_lkv = 0; m_lkn = 0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
